multibyte_add_seq: RTL



---
 rtl/multibyte_add_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: wide add via one 8-bit ripple adder, LSB byte first; optional subtract with MBADD_SUB_EN
module multibyte_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   a_in,
   input  logic [8*NBYTES-1:0]   b_in,
   input  logic                  cin_in,
`ifdef MBADD_SUB_EN
   input  logic                  sub_in,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   sum_out,
   output logic                  cout_out,
   output logic                  busy
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);
   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;
   state_t          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_sum;
   logic            r_carry;
   logic            r_sub;
   logic [IW-1:0]   r_idx;
   logic            w_sub_in;
   logic [7:0]      w_b;
   logic [7:0]      w_s;
   logic            w_co;
`ifdef MBADD_SUB_EN
   assign w_sub_in = sub_in;
`else
   assign w_sub_in = 1'b0;
`endif
   assign w_b = r_sub ? ~r_b[7:0] : r_b[7:0];
   // eight chained full-adder cells on the current low byte
   always_comb begin : byte_adder
      logic c;
      c   = r_carry;
      w_s = '0;
      for (int i = 0; i < 8; i++) begin
         w_s[i] = r_a[i] ^ w_b[i] ^ c;
         c      = (r_a[i] & w_b[i]) | (c & (r_a[i] ^ w_b[i]));
      end
      w_co = c;
   end
   // control FSM and datapath registers, outputs registered alongside state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_sum     <= '0;
         r_carry   <= 1'b0;
         r_sub     <= 1'b0;
         r_idx     <= '0;
         sum_out   <= '0;
         cout_out  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_a      <= a_in;
               r_b      <= b_in;
               r_sub    <= w_sub_in;
               r_carry  <= w_sub_in | cin_in;
               r_idx    <= '0;
               r_state  <= S_ADD;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
            S_ADD: begin
               r_sum   <= {w_s, r_sum[W-1:8]};
               r_a     <= r_a >> 8;
               r_b     <= r_b >> 8;
               r_carry <= w_co;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == IW'(NBYTES - 1)) begin
                  sum_out   <= {w_s, r_sum[W-1:8]};
                  cout_out  <= w_co;
                  out_valid <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: if (out_ready) begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               r_state   <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
